// File: rtl/fetch_pkg.sv
// Shared types and helpers for the instruction fetch controller.
package fetch_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StRequest,
    StWait,
    StDeliver,
    StFlush,
    StFault
  } fetch_state_t;

  typedef enum logic [1:0] {
    SelNone,
    SelTrap,
    SelBranch,
    SelJump
  } redirect_sel_t;

  localparam logic StrideHalf = 1'b0;
  localparam logic StrideWord = 1'b1;

  // Full-width (32-bit) encodings have both low opcode bits set.
  function automatic logic is_full_width(input logic [31:0] instr);
    return instr[1:0] == 2'b11;
  endfunction

endpackage

// File: rtl/redirect_arbiter.sv
// Fixed-priority redirect select: trap over branch over jump.
module redirect_arbiter
  import fetch_pkg::*;
(
  input  logic          i_TrapRedirect,
  input  logic [31:0]   i_TrapAddress,
  input  logic          i_BranchRedirect,
  input  logic [31:0]   i_BranchAddress,
  input  logic          i_JumpRedirect,
  input  logic [31:0]   i_JumpAddress,
  output logic          o_Active,
  output redirect_sel_t o_Select,
  output logic [31:0]   o_Address,
  output logic          o_Misaligned
);

  logic [31:0] target;

  always_comb begin
    o_Select = SelNone;
    target   = '0;
    if (i_TrapRedirect) begin
      o_Select = SelTrap;
      target   = i_TrapAddress;
    end else if (i_BranchRedirect) begin
      o_Select = SelBranch;
      target   = i_BranchAddress;
    end else if (i_JumpRedirect) begin
      o_Select = SelJump;
      target   = i_JumpAddress;
    end
  end

  assign o_Active     = (o_Select != SelNone);
  assign o_Address    = {target[31:1], 1'b0};
  assign o_Misaligned = target[0];

endmodule

// File: rtl/fetch_controller.sv
// Single-outstanding instruction fetch sequencer with redirect arbitration and
// stale-response flushing.
module fetch_controller
  import fetch_pkg::*;
#(
  parameter int unsigned ResponseTimeout = 255,
  parameter int unsigned TimeoutWidth    = 8
) (
  input  logic        i_Clock,
  input  logic        i_Reset,
  input  logic [31:0] i_PointerAddress,
  output logic        o_Load,
  output logic [31:0] o_LoadAddress,
  output logic        o_Stride,
  output logic        o_Stall,
  output logic        o_FetchValid,
  output logic [31:0] o_FetchAddress,
  input  logic        i_FetchReady,
  input  logic        i_ResponseValid,
  input  logic [31:0] i_ResponseData,
  output logic        o_InstructionValid,
  output logic [31:0] o_Instruction,
  output logic [31:0] o_InstructionAddress,
  input  logic        i_InstructionReady,
  input  logic        i_TrapRedirect,
  input  logic [31:0] i_TrapAddress,
  input  logic        i_BranchRedirect,
  input  logic [31:0] i_BranchAddress,
  input  logic        i_JumpRedirect,
  input  logic [31:0] i_JumpAddress,
  output logic        o_Misaligned,
  output logic        o_FetchFault
);

  localparam bit                    TimeoutOn   = (ResponseTimeout != 0);
  localparam logic [TimeoutWidth-1:0] TimeoutLast = TimeoutWidth'(ResponseTimeout - 1);

  fetch_state_t            state_q, state_d;
  logic [31:0]             buf_q, buf_d;
  logic [31:0]             buf_addr_q, buf_addr_d;
  logic [TimeoutWidth-1:0] cnt_q, cnt_d;

  logic          arb_active;
  redirect_sel_t arb_sel;
  logic [31:0]   arb_addr;
  logic          arb_misaligned;

  redirect_arbiter u_redirect_arbiter (
    .i_TrapRedirect   (i_TrapRedirect),
    .i_TrapAddress    (i_TrapAddress),
    .i_BranchRedirect (i_BranchRedirect),
    .i_BranchAddress  (i_BranchAddress),
    .i_JumpRedirect   (i_JumpRedirect),
    .i_JumpAddress    (i_JumpAddress),
    .o_Active         (arb_active),
    .o_Select         (arb_sel),
    .o_Address        (arb_addr),
    .o_Misaligned     (arb_misaligned)
  );

  logic redirect;
  logic waiting;
  logic timed_out;

  assign redirect  = arb_active && (arb_sel != SelNone) && (state_q != StIdle);
  assign waiting   = (state_q == StWait) || (state_q == StFlush);
  assign timed_out = TimeoutOn && (cnt_q == TimeoutLast);

  always_comb begin
    state_d              = state_q;
    buf_d                = buf_q;
    buf_addr_d           = buf_addr_q;
    o_Load               = 1'b0;
    o_LoadAddress        = '0;
    o_Stride             = StrideHalf;
    o_Stall              = 1'b1;
    o_FetchValid         = 1'b0;
    o_FetchAddress       = '0;
    o_InstructionValid   = 1'b0;
    o_Instruction        = '0;
    o_InstructionAddress = '0;
    o_Misaligned         = 1'b0;
    o_FetchFault         = 1'b0;

    case (state_q)
      StIdle: state_d = StRequest;
      StRequest: begin
        o_FetchValid   = 1'b1;
        o_FetchAddress = i_PointerAddress;
        if (i_FetchReady) begin
          buf_addr_d = i_PointerAddress;
          state_d    = StWait;
        end
      end
      StWait: begin
        if (i_ResponseValid) begin
          buf_d   = i_ResponseData;
          state_d = StDeliver;
        end else if (timed_out) begin
          state_d = StFault;
        end
      end
      StDeliver: begin
        o_InstructionValid   = 1'b1;
        o_Instruction        = buf_q;
        o_InstructionAddress = buf_addr_q;
        if (i_InstructionReady) begin
          o_Stall  = 1'b0;
          o_Stride = is_full_width(buf_q) ? StrideWord : StrideHalf;
          state_d  = StRequest;
        end
      end
      StFlush: begin
        if (i_ResponseValid) begin
          state_d = StRequest;
        end else if (timed_out) begin
          state_d = StFault;
        end
      end
      StFault: o_FetchFault = 1'b1;
      default: state_d = StIdle;
    endcase

    // A redirect overrides everything above; a pending response must still be drained.
    if (redirect) begin
      o_Load               = 1'b1;
      o_LoadAddress        = arb_addr;
      o_Misaligned         = arb_misaligned;
      o_Stall              = 1'b0;
      o_Stride             = StrideHalf;
      o_FetchValid         = 1'b0;
      o_FetchAddress       = '0;
      o_InstructionValid   = 1'b0;
      o_Instruction        = '0;
      o_InstructionAddress = '0;
      buf_d                = '0;
      buf_addr_d           = buf_addr_q;
      state_d              = (waiting && !i_ResponseValid) ? StFlush : StRequest;
    end

    if (waiting && ((state_d == StWait) || (state_d == StFlush))) begin
      cnt_d = cnt_q + TimeoutWidth'(1);
    end else begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge i_Clock or negedge i_Reset) begin
    if (!i_Reset) begin
      state_q    <= StIdle;
      buf_q      <= '0;
      buf_addr_q <= '0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      buf_q      <= buf_d;
      buf_addr_q <= buf_addr_d;
      cnt_q      <= cnt_d;
    end
  end

endmodule

// File: tb/tb_fetch_controller.sv
// Self-checking bench: pointer and memory environment plus a transaction-level
// reference model of the fetch contract, checked every cycle.
module tb_fetch_controller;

  localparam int unsigned TO = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [31:0] ptr;
  logic        o_Load, o_Stride, o_Stall, o_FetchValid;
  logic [31:0] o_LoadAddress, o_FetchAddress, o_Instruction, o_InstructionAddress;
  logic        i_FetchReady = 1'b0, i_ResponseValid = 1'b0, i_InstructionReady = 1'b0;
  logic [31:0] i_ResponseData = '0;
  logic        o_InstructionValid, o_Misaligned, o_FetchFault;
  logic        trap = 1'b0, branch = 1'b0, jump = 1'b0;
  logic [31:0] ta = '0, ba = '0, ja = '0;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  fetch_controller #(.ResponseTimeout(TO), .TimeoutWidth(8)) dut (
    .i_Clock              (clk),
    .i_Reset              (rst_n),
    .i_PointerAddress     (ptr),
    .o_Load               (o_Load),
    .o_LoadAddress        (o_LoadAddress),
    .o_Stride             (o_Stride),
    .o_Stall              (o_Stall),
    .o_FetchValid         (o_FetchValid),
    .o_FetchAddress       (o_FetchAddress),
    .i_FetchReady         (i_FetchReady),
    .i_ResponseValid      (i_ResponseValid),
    .i_ResponseData       (i_ResponseData),
    .o_InstructionValid   (o_InstructionValid),
    .o_Instruction        (o_Instruction),
    .o_InstructionAddress (o_InstructionAddress),
    .i_InstructionReady   (i_InstructionReady),
    .i_TrapRedirect       (trap),
    .i_TrapAddress        (ta),
    .i_BranchRedirect     (branch),
    .i_BranchAddress      (ba),
    .i_JumpRedirect       (jump),
    .i_JumpAddress        (ja),
    .o_Misaligned         (o_Misaligned),
    .o_FetchFault         (o_FetchFault)
  );

  // Instruction pointer environment: load wins over advance, stall holds.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr <= 32'h0040_0000;
    else if (o_Load) ptr <= o_LoadAddress;
    else if (!o_Stall) ptr <= ptr + (o_Stride ? 32'd4 : 32'd2);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic chkb(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b required %b (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Memory image: 0 = all addi, 1 = table, 2 = address hash
  int          img_mode = 0;
  logic [31:0] mem_tab [logic [31:0]];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [31:0] h;
    if (img_mode == 0) return 32'h0000_0013;
    if (img_mode == 1) return mem_tab.exists(a) ? mem_tab[a] : 32'h0000_0013;
    h = (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    if (h[7]) h[1:0] = 2'b11;
    return h;
  endfunction

  int          due_q[$];
  logic [31:0] raddr_q[$];
  int          lat_min = 1, lat_max = 1;
  bit          mem_mute = 1'b0;

  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (!rst_n) begin
        due_q.delete();
        raddr_q.delete();
        i_ResponseValid = 1'b0;
        i_ResponseData  = '0;
      end else if (!mem_mute && due_q.size() > 0 && cyc >= due_q[0]) begin
        i_ResponseValid = 1'b1;
        i_ResponseData  = mem_word(raddr_q[0]);
        void'(due_q.pop_front());
        void'(raddr_q.pop_front());
      end else begin
        i_ResponseValid = 1'b0;
        i_ResponseData  = '0;
      end
    end
  end

  // Reference model state
  logic [31:0] m_pc = 32'h0040_0000;
  logic [31:0] m_held = '0;
  bit          m_out = 0, m_stale = 0, m_have = 0, m_fault = 0, m_boot = 1;
  int          m_wait = 0;
  logic [31:0] fetch_log[$];
  logic [31:0] deliv_log[$];
  bit          stride_log[$];

  task automatic check_quiet(input string p);
    chkb({p, "_stall"}, o_Stall, 1'b1);
    chkb({p, "_load"}, o_Load, 1'b0);
    chk({p, "_load_addr"}, o_LoadAddress, 32'h0);
    chkb({p, "_stride"}, o_Stride, 1'b0);
    chkb({p, "_fetch_valid"}, o_FetchValid, 1'b0);
    chk({p, "_fetch_addr"}, o_FetchAddress, 32'h0);
    chkb({p, "_instr_valid"}, o_InstructionValid, 1'b0);
    chk({p, "_instr"}, o_Instruction, 32'h0);
    chk({p, "_instr_addr"}, o_InstructionAddress, 32'h0);
    chkb({p, "_misaligned"}, o_Misaligned, 1'b0);
    chkb({p, "_fault"}, o_FetchFault, 1'b0);
  endtask

  always @(negedge clk) begin
    logic        redir, accept, full, exp_fv;
    logic [31:0] tgt;
    if (!rst_n) begin
      check_quiet("reset");
      m_pc = 32'h0040_0000; m_out = 0; m_stale = 0; m_have = 0; m_fault = 0;
      m_boot = 1; m_wait = 0;
    end else if (m_boot) begin
      check_quiet("idle");
      m_boot = 0;
    end else begin
      redir = trap | branch | jump;
      tgt   = trap ? ta : branch ? ba : jump ? ja : 32'h0;
      chkb("fault", o_FetchFault, m_fault);
      if (redir) begin
        chkb("redir_load", o_Load, 1'b1);
        chk("redir_load_addr", o_LoadAddress, {tgt[31:1], 1'b0});
        chkb("redir_misaligned", o_Misaligned, tgt[0]);
        chkb("redir_stall", o_Stall, 1'b0);
        chkb("redir_stride", o_Stride, 1'b0);
        chkb("redir_fetch_valid", o_FetchValid, 1'b0);
        chkb("redir_instr_valid", o_InstructionValid, 1'b0);
        m_pc    = {tgt[31:1], 1'b0};
        m_have  = 0;
        m_fault = 0;
        if (m_out) begin
          if (i_ResponseValid) m_out = 0;
          else begin m_stale = 1; m_wait++; end
        end
      end else begin
        exp_fv = !m_fault && !m_out && !m_have;
        chkb("load", o_Load, 1'b0);
        chk("load_addr", o_LoadAddress, 32'h0);
        chkb("misaligned", o_Misaligned, 1'b0);
        chkb("fetch_valid", o_FetchValid, exp_fv);
        chk("fetch_addr", o_FetchAddress, exp_fv ? m_pc : 32'h0);
        chkb("instr_valid", o_InstructionValid, m_have);
        chk("instr", o_Instruction, m_have ? m_held : 32'h0);
        chk("instr_addr", o_InstructionAddress, m_have ? m_pc : 32'h0);
        accept = m_have && i_InstructionReady;
        full   = (m_held[1:0] == 2'b11);
        chkb("stall", o_Stall, !accept);
        chkb("stride", o_Stride, accept && full);
        if (exp_fv && i_FetchReady) begin
          m_out = 1; m_stale = 0; m_wait = 0;
          fetch_log.push_back(m_pc);
        end else if (m_out) begin
          if (i_ResponseValid) begin
            m_out = 0;
            if (!m_stale) begin m_have = 1; m_held = mem_word(m_pc); end
          end else begin
            if (m_wait == int'(TO) - 1) begin m_fault = 1; m_out = 0; end
            m_wait++;
          end
        end
        if (accept) begin
          stride_log.push_back(full);
          deliv_log.push_back(m_pc);
          m_pc   = m_pc + (full ? 32'd4 : 32'd2);
          m_have = 0;
        end
      end
      if (o_FetchValid && i_FetchReady) begin
        due_q.push_back(cyc + int'($urandom_range(lat_max, lat_min)));
        raddr_q.push_back(o_FetchAddress);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // kind: 0 = fetch log, 1 = stride log, 2 = delivery log
  task automatic wait_log(input int kind, input int n, input string nm);
    bit ok = 0;
    int sz;
    for (int k = 0; k < 300; k++) begin
      step();
      sz = (kind == 0) ? fetch_log.size() : (kind == 1) ? stride_log.size() : deliv_log.size();
      if (sz >= n) begin ok = 1; break; end
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: timed out, got %0d entries required %0d", nm, sz, n);
    end
  endtask

  task automatic do_reset();
    step();
    rst_n = 1'b0;
    trap = 0; branch = 0; jump = 0;
    step();
    fetch_log.delete(); deliv_log.delete(); stride_log.delete();
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    #1 rst_n = 1'b0;
    i_FetchReady = 1'b1;
    i_InstructionReady = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chkb("lit_reset_stall", o_Stall, 1'b1);
    chkb("lit_reset_fetch_valid", o_FetchValid, 1'b0);

    // Boot: all full-width instructions
    step();
    rst_n = 1'b1;
    wait_log(1, 3, "boot_wait");
    chk("lit_boot_fetch0", fetch_log[0], 32'h0040_0000);
    chk("lit_boot_fetch1", fetch_log[1], 32'h0040_0004);
    chk("lit_boot_fetch2", fetch_log[2], 32'h0040_0008);
    for (int i = 0; i < 3; i++) chkb("lit_boot_stride", stride_log[i], 1'b1);

    // Compressed mix
    img_mode = 1;
    mem_tab[32'h0040_0000] = 32'h0000_4501;
    mem_tab[32'h0040_0002] = 32'h0000_0013;
    mem_tab[32'h0040_0006] = 32'h0000_4502;
    do_reset();
    wait_log(1, 3, "mix_wait");
    chk("lit_mix_fetch0", fetch_log[0], 32'h0040_0000);
    chk("lit_mix_fetch1", fetch_log[1], 32'h0040_0002);
    chk("lit_mix_fetch2", fetch_log[2], 32'h0040_0006);
    chkb("lit_mix_stride0", stride_log[0], 1'b0);
    chkb("lit_mix_stride1", stride_log[1], 1'b1);
    chkb("lit_mix_stride2", stride_log[2], 1'b0);

    // Decode backpressure
    img_mode = 0;
    i_InstructionReady = 1'b0;
    do_reset();
    for (int k = 0; k < 50 && !o_InstructionValid; k++) step();
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chkb("lit_bp_valid", o_InstructionValid, 1'b1);
      chkb("lit_bp_stall", o_Stall, 1'b1);
      chkb("lit_bp_fetch_valid", o_FetchValid, 1'b0);
      chk("lit_bp_addr", o_InstructionAddress, 32'h0040_0000);
      chk("lit_bp_ptr", ptr, 32'h0040_0000);
      step();
    end
    i_InstructionReady = 1'b1;
    @(negedge clk);
    chkb("lit_bp_accept_stall", o_Stall, 1'b0);
    chkb("lit_bp_accept_stride", o_Stride, 1'b1);
    step();
    i_InstructionReady = 1'b0;
    chk("lit_bp_ptr_adv", ptr, 32'h0040_0004);
    step();
    chk("lit_bp_ptr_once", ptr, 32'h0040_0004);
    i_InstructionReady = 1'b1;

    // Redirect priority and flush of the in-flight response
    lat_min = 3; lat_max = 3;
    do_reset();
    wait_log(0, 1, "prio_wait_fetch");
    trap = 1; ta = 32'h0000_0100; branch = 1; ba = 32'h0000_0200;
    @(negedge clk);
    chkb("lit_prio_load", o_Load, 1'b1);
    chk("lit_prio_load_addr", o_LoadAddress, 32'h0000_0100);
    step();
    trap = 0; branch = 0;
    wait_log(2, 1, "prio_wait_deliver");
    chk("lit_prio_fetch1", fetch_log[1], 32'h0000_0100);
    chk("lit_prio_deliver0", deliv_log[0], 32'h0000_0100);

    // Misaligned jump
    lat_min = 1; lat_max = 2;
    repeat (7) step();
    fetch_log.delete();
    jump = 1; ja = 32'hFEED_FACF;
    @(negedge clk);
    chkb("lit_mis_pulse", o_Misaligned, 1'b1);
    chk("lit_mis_load_addr", o_LoadAddress, 32'hFEED_FACE);
    step();
    jump = 0;
    @(negedge clk);
    chkb("lit_mis_one_cycle", o_Misaligned, 1'b0);
    wait_log(0, 1, "mis_wait_fetch");
    chk("lit_mis_fetch", fetch_log[0], 32'hFEED_FACE);

    // Response timeout, recovery by trap, then reset mid-wait
    lat_min = 1; lat_max = 1;
    mem_mute = 1;
    do_reset();
    wait_log(0, 1, "to_wait_fetch");
    repeat (3) step();
    @(negedge clk);
    chkb("lit_to_not_yet", o_FetchFault, 1'b0);
    step();
    @(negedge clk);
    chkb("lit_to_fault", o_FetchFault, 1'b1);
    for (int k = 0; k < 4; k++) begin
      step();
      @(negedge clk);
      chkb("lit_to_no_fetch", o_FetchValid, 1'b0);
    end
    step();
    due_q.delete(); raddr_q.delete();
    mem_mute = 0;
    fetch_log.delete();
    trap = 1; ta = 32'h0;
    @(negedge clk);
    chkb("lit_to_trap_load", o_Load, 1'b1);
    step();
    trap = 0;
    wait_log(0, 1, "to_wait_recover");
    chk("lit_to_fetch0", fetch_log[0], 32'h0);
    lat_min = 3; lat_max = 3;
    fetch_log.delete();
    wait_log(0, 1, "rstw_wait_fetch");
    rst_n = 1'b0;
    #1;
    chkb("lit_rstw_stall", o_Stall, 1'b1);
    chkb("lit_rstw_fetch_valid", o_FetchValid, 1'b0);
    chkb("lit_rstw_instr_valid", o_InstructionValid, 1'b0);
    chk("lit_rstw_fetch_addr", o_FetchAddress, 32'h0);
    step();
    rst_n = 1'b1;

    // Randomized traffic
    img_mode = 2;
    lat_min = 1; lat_max = 3;
    for (int k = 0; k < 3000; k++) begin
      step();
      i_FetchReady       = ($urandom_range(9, 0) < 7);
      i_InstructionReady = ($urandom_range(9, 0) < 6);
      trap   = ($urandom_range(99, 0) < 2);
      branch = ($urandom_range(99, 0) < 3);
      jump   = ($urandom_range(99, 0) < 4);
      ta = $urandom; ba = $urandom; ja = $urandom;
    end
    step();
    trap = 0; branch = 0; jump = 0;
    repeat (10) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d checks %0d errors", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
